// File: rtl/adder.sv
// posit<N,ES> adder: decode both operands, align, add/subtract, normalise,
// re-encode with round-to-nearest-even on the bit string; result registered.
module adder #(
  parameter int N  = 16,
  parameter int ES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] posit
);

  localparam int FW    = N - 1 - ES;
  localparam int MW    = FW + 1;
  localparam int SW    = $clog2(N) + ES + 3;
  localparam int SMW   = MW + 2;
  localparam int AW    = MW + 4;
  localparam int FR    = AW - 1;
  localparam int ZW    = 2 + ES + FR + N;
  localparam int LW    = $clog2(AW + 1);
  localparam int DW    = $clog2(SMW + 1);
  localparam int MAXSC = (N - 2) << ES;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  // Returns {scale, 1.fraction}; truncated exponent bits come out as zero.
  function automatic logic [SW+MW-1:0] decode(input logic [N-1:0] v);
    logic [N-2:0] r;
    logic [N-2:0] tmp;
    logic         lead;
    logic         more;
    int           run;
    logic signed [SW-1:0] k;
    logic signed [SW-1:0] sc;
    r    = v[N-1] ? -v[N-2:0] : v[N-2:0];
    lead = r[N-2];
    run  = 0;
    more = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (more && (r[i] == lead)) run++;
      else more = 1'b0;
    end
    k   = lead ? SW'(run - 1) : SW'(-run);
    tmp = r << (run + 1);
    sc  = (k <<< ES) + $signed({{(SW-ES){1'b0}}, tmp[N-2 -: ES]});
    return {sc, 1'b1, tmp[FW-1:0]};
  endfunction

  function automatic logic [LW-1:0] lzc(input logic [AW-1:0] v);
    logic [LW-1:0] n;
    logic          done;
    n    = '0;
    done = 1'b0;
    for (int i = AW - 1; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) done = 1'b1;
        else n = n + 1'b1;
      end
    end
    return n;
  endfunction

  // Regime is produced by arithmetic-shifting a 2-bit seed (10 or 01), so the
  // rounding below sees the exact bit string that would be truncated.
  function automatic logic [N-1:0] encode(input logic s,
                                          input logic signed [SW-1:0] sc,
                                          input logic [FR-1:0] fr);
    logic signed [SW-1:0] k;
    logic [ES-1:0]        e;
    logic signed [ZW-1:0] z;
    logic [N-2:0]         body;
    logic                 g;
    logic                 st;
    logic [N-1:0]         mag;
    int                   sh;
    k = sc >>> ES;
    e = sc[ES-1:0];
    z = '0;
    if (sc >= SW'(MAXSC)) begin
      mag = {1'b0, {(N-1){1'b1}}};
    end else if (sc < -SW'(MAXSC)) begin
      mag = {{(N-1){1'b0}}, 1'b1};
    end else begin
      z    = {(k[SW-1] ? 2'b01 : 2'b10), e, fr, {N{1'b0}}};
      sh   = int'(k[SW-1] ? ~k : k);
      z    = z >>> sh;
      body = z[ZW-1 -: N-1];
      g    = z[ZW-N];
      st   = |z[ZW-N-1:0];
      mag  = {1'b0, body + (N-1)'(g & (st | body[0]))};
    end
    return s ? -mag : mag;
  endfunction

  logic signed [SW-1:0] sc_x_p0, sc_y_p0, sc_l_p0, sc_s_p0, sc_r_p0;
  logic [MW-1:0]        m_x_p0, m_y_p0, m_l_p0, m_s_p0;
  logic                 x_big_p0, s_l_p0, lost_p0;
  logic signed [SW:0]   diff_p0;
  logic [DW-1:0]        dc_p0;
  logic [SMW-1:0]       ms_ext_p0, ms_sh_p0;
  logic [AW-1:0]        a_l_p0, a_s_p0, sum_p0;
  logic [LW-1:0]        lz_p0;
  logic [FR-1:0]        frac_p0;
  logic [N-1:0]         posit_d, posit_q;

  assign {sc_x_p0, m_x_p0} = decode(x);
  assign {sc_y_p0, m_y_p0} = decode(y);

  // Stage p0: align, add, normalise, encode.
  always_comb begin
    x_big_p0  = (sc_x_p0 > sc_y_p0) || ((sc_x_p0 == sc_y_p0) && (m_x_p0 >= m_y_p0));
    sc_l_p0   = x_big_p0 ? sc_x_p0 : sc_y_p0;
    sc_s_p0   = x_big_p0 ? sc_y_p0 : sc_x_p0;
    m_l_p0    = x_big_p0 ? m_x_p0 : m_y_p0;
    m_s_p0    = x_big_p0 ? m_y_p0 : m_x_p0;
    s_l_p0    = x_big_p0 ? x[N-1] : y[N-1];
    diff_p0   = {sc_l_p0[SW-1], sc_l_p0} - {sc_s_p0[SW-1], sc_s_p0};
    dc_p0     = (diff_p0 > (SW+1)'(SMW)) ? DW'(SMW) : diff_p0[DW-1:0];
    ms_ext_p0 = {m_s_p0, 2'b00};
    ms_sh_p0  = ms_ext_p0 >> dc_p0;
    lost_p0   = |(ms_ext_p0 & ~({SMW{1'b1}} << dc_p0));
    // Sticky lives in its own LSB slot so subtraction rounds correctly.
    a_l_p0    = {1'b0, m_l_p0, 3'b000};
    a_s_p0    = {1'b0, ms_sh_p0, lost_p0};
    sum_p0    = (x[N-1] == y[N-1]) ? a_l_p0 + a_s_p0 : a_l_p0 - a_s_p0;
    lz_p0     = lzc(sum_p0);
    frac_p0   = FR'(sum_p0 << lz_p0);
    sc_r_p0   = sc_l_p0 + SW'(1) - $signed({{(SW-LW){1'b0}}, lz_p0});
    if ((x == NAR) || (y == NAR)) posit_d = NAR;
    else if (x == '0)             posit_d = y;
    else if (y == '0)             posit_d = x;
    else if (sum_p0 == '0)        posit_d = '0;
    else                          posit_d = encode(s_l_p0, sc_r_p0, frac_p0);
  end

  // Stage p1: output register.
  always_ff @(posedge clk) begin
    if (rst) posit_q <= '0;
    else     posit_q <= posit_d;
  end

  assign posit = posit_q;

endmodule

// File: tb/tb_adder.sv
// Randomised scoreboard bench for the posit<16,3> adder against a
// real-arithmetic reference model.
module tb_adder;

  localparam logic [15:0] NAR = 16'h8000;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x, y;
  logic [15:0] posit;
  logic        in_vld = 1'b0;
  logic        out_vld = 1'b0;
  logic        done = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cycles = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } entry_t;

  entry_t q[$];
  string  nq[$];

  adder #(.N(16), .ES(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .posit(posit)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    for (int i = 0; i < n; i++) r = r * 2.0;
    for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real p2r(input logic [15:0] p);
    logic [15:0] m;
    logic        lead;
    int          i, run, k, e;
    real         f, w, v;
    if (p == 16'h0000) return 0.0;
    m    = p[15] ? -p : p;
    i    = 14;
    lead = m[14];
    run  = 0;
    while (i >= 0 && m[i] == lead) begin
      run++;
      i--;
    end
    k = lead ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < 3; j++) begin
      e = e * 2 + ((i >= 0) ? int'(m[i]) : 0);
      i--;
    end
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin
      if (m[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    v = f * pow2(k * 8 + e);
    return p[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2p(input real v);
    logic         s;
    real          a, f;
    int           sc, k, e, n;
    logic [2:0]   eb;
    logic [127:0] bs;
    logic [14:0]  body;
    logic         g, st;
    logic [15:0]  mag;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a >= pow2(112)) begin
      mag = 16'h7FFF;
    end else if (a < pow2(-112)) begin
      mag = 16'h0001;
    end else begin
      sc = 0;
      while (a >= 2.0) begin a = a / 2.0; sc++; end
      while (a < 1.0) begin a = a * 2.0; sc--; end
      k  = (sc >= 0) ? sc / 8 : -((-sc + 7) / 8);
      e  = sc - 8 * k;
      eb = e[2:0];
      bs = '0;
      n  = 0;
      if (k >= 0) begin
        for (int j = 0; j <= k; j++) begin bs[127-n] = 1'b1; n++; end
        bs[127-n] = 1'b0; n++;
      end else begin
        for (int j = 0; j < -k; j++) begin bs[127-n] = 1'b0; n++; end
        bs[127-n] = 1'b1; n++;
      end
      for (int j = 2; j >= 0; j--) begin bs[127-n] = eb[j]; n++; end
      f = a - 1.0;
      for (int j = 0; j < 60; j++) begin
        f = f * 2.0;
        if (f >= 1.0) begin bs[127-n] = 1'b1; f = f - 1.0; end
        n++;
      end
      body = bs[127 -: 15];
      g    = bs[112];
      st   = (|bs[111:0]) || (f != 0.0);
      body = body + 15'(g & (st | body[0]));
      mag  = {1'b0, body};
    end
    return s ? -mag : mag;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    if (a == NAR || b == NAR) return NAR;
    return r2p(p2r(a) + p2r(b));
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic r, input string nm);
    entry_t ent;
    @(negedge clk);
    x      = a;
    y      = b;
    rst    = r;
    in_vld = 1'b1;
    ent.a   = a;
    ent.b   = b;
    ent.exp = r ? 16'h0000 : model(a, b);
    q.push_back(ent);
    nq.push_back(nm);
  endtask

  task automatic drive_const(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] want, input string nm);
    entry_t ent;
    @(negedge clk);
    x      = a;
    y      = b;
    rst    = 1'b0;
    in_vld = 1'b1;
    ent.a   = a;
    ent.b   = b;
    ent.exp = want;
    q.push_back(ent);
    nq.push_back(nm);
  endtask

  task automatic drive_rand(input logic r);
    logic [15:0] a, b;
    int          kind;
    a    = 16'($urandom);
    b    = 16'($urandom);
    kind = $urandom_range(0, 11);
    case (kind)
      0: b = NAR;
      1: b = 16'h0000;
      2: b = -a;
      3: b = a;
      4: b = a ^ 16'($urandom_range(0, 15));
      5: b = -(a ^ 16'($urandom_range(1, 7)));
      6: a = 16'h0000;
      7: a = NAR;
      8: b = {b[15], 4'b0000, b[10:0]};
      default: ;
    endcase
    drive(a, b, r, r ? "reset_mid" : "rand");
  endtask

  always @(posedge clk) out_vld <= in_vld;

  always @(negedge clk) begin
    entry_t ent;
    string  nm;
    cycles++;
    if (out_vld) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output posit=%h required=none", posit);
      end else begin
        ent = q.pop_front();
        nm  = nq.pop_front();
        if (posit !== ent.exp) begin
          errors++;
          $display("FAIL %s x=%h y=%h posit=%h required=%h", nm, ent.a, ent.b, posit, ent.exp);
        end
      end
    end
    if (done || cycles > LIMIT) begin
      checks++;
      if (cycles > LIMIT) begin
        errors++;
        $display("FAIL timeout cycles=%0d required<=%0d", cycles, LIMIT);
      end else if (q.size() != 0) begin
        errors++;
        $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  logic [15:0] dx [0:19] = '{16'h8000, 16'h9C48, 16'h8000, 16'h0000, 16'h5A3C,
                             16'hCCF9, 16'h3307, 16'h4000, 16'h4800, 16'h5000,
                             16'hC000, 16'hB800, 16'hB400, 16'h4400, 16'hC000,
                             16'hB400, 16'h4800, 16'h7FA0, 16'h0080, 16'h7FFF};
  logic [15:0] dy [0:19] = '{16'h9C48, 16'h8000, 16'h8000, 16'h5A3C, 16'h0000,
                             16'h3307, 16'hCCF9, 16'h4000, 16'h5000, 16'h4800,
                             16'hC000, 16'hB400, 16'hB800, 16'hC000, 16'h4400,
                             16'h4800, 16'hB400, 16'h4008, 16'h4800, 16'h7FFF};
  logic [15:0] dz [0:19] = '{16'h8000, 16'h8000, 16'h8000, 16'h5A3C, 16'h5A3C,
                             16'h0000, 16'h0000, 16'h4400, 16'h5100, 16'h5100,
                             16'hBC00, 16'hB200, 16'hB200, 16'h4000, 16'h4000,
                             16'hB800, 16'hB800, 16'h7FA0, 16'h4800, 16'h7FFF};

  initial begin
    rst = 1'b1;
    x   = 16'h0000;
    y   = 16'h0000;
    drive(16'h4000, 16'h4000, 1'b1, "reset");
    drive(16'h1234, 16'h7000, 1'b1, "reset");
    drive_const(16'h4000, 16'h4000, 16'h4400, "first_after_reset");
    for (int i = 0; i < 20; i++) drive_const(dx[i], dy[i], dz[i], "directed");
    for (int i = 0; i < 1500; i++) drive_rand(1'b0);
    drive_rand(1'b1);
    drive_rand(1'b1);
    drive_const(16'h4000, 16'h4000, 16'h4400, "first_after_reset2");
    for (int i = 0; i < 400; i++) drive_rand(1'b0);
    @(negedge clk);
    in_vld = 1'b0;
    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule
